// File: rtl/wb_trace_fifo.sv
`default_nettype none
// ============================================================================
// wb_trace_fifo : show-ahead FIFO of retiring register writes from writeback,
//                 with a sticky overflow flag and saturating drop counter.
// Revision      : 1.0
// ============================================================================
module wb_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              debug_wb_pc,
  input  logic [3:0]               debug_wb_rf_wen,
  input  logic [4:0]               debug_wb_rf_wnum,
  input  logic [31:0]              debug_wb_rf_wdata,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [31:0]              trace_pc,
  output logic [3:0]               trace_wen,
  output logic [4:0]               trace_wnum,
  output logic [31:0]              trace_wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [CW-1:0]            drop_cnt,
  input  logic                     clr_ovf
);

  localparam int              c_aw       = $clog2(DEPTH);
  localparam int              c_ew       = 73;
  localparam logic [c_aw:0]   c_full     = (c_aw + 1)'(DEPTH);
  localparam logic [CW-1:0]   c_drop_max = {CW{1'b1}};

  logic [c_ew-1:0] r_mem [DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw:0]   r_count;
  logic            r_overflow;
  logic [CW-1:0]   r_drop_cnt;

  logic            w_capture;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic [c_ew-1:0] w_head;

  assign w_capture = (debug_wb_rf_wen != 4'b0000) && (debug_wb_rf_wnum != 5'd0);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_full);
  assign w_pop     = !w_empty && trace_ready;
  // A full FIFO still accepts a capture when the head leaves in the same cycle.
  assign w_push    = w_capture && (!w_full || w_pop);
  assign w_drop    = w_capture && w_full && !w_pop;

  // Storage is deliberately left unreset; it is masked while empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_aw'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_aw'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_aw + 1)'(1);
        2'b01:   r_count <= r_count - (c_aw + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A drop in the same cycle as a clear wins, restarting the tally at one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clr_ovf) begin
        r_drop_cnt <= CW'(1);
      end else if (r_drop_cnt != c_drop_max) begin
        r_drop_cnt <= r_drop_cnt + CW'(1);
      end
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  assign w_head      = r_mem[r_rd_ptr];
  assign trace_valid = !w_empty;
  assign {trace_pc, trace_wen, trace_wnum, trace_wdata} = trace_valid ? w_head : '0;
  assign count       = r_count;
  assign overflow    = r_overflow;
  assign drop_cnt    = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wb_trace_fifo.sv
`default_nettype none
// ============================================================================
// tb_wb_trace_fifo : directed bench for wb_trace_fifo against a queue model.
// Revision         : 1.0
// ============================================================================
module tb_wb_trace_fifo;

  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam int SAT   = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] debug_wb_pc = '0;
  logic [3:0]  debug_wb_rf_wen = '0;
  logic [4:0]  debug_wb_rf_wnum = '0;
  logic [31:0] debug_wb_rf_wdata = '0;
  logic        trace_ready = 1'b0;
  logic        clr_ovf = 1'b0;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [3:0]  trace_wen;
  logic [4:0]  trace_wnum;
  logic [31:0] trace_wdata;
  logic [3:0]  count;
  logic        overflow;
  logic [CW-1:0] drop_cnt;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  wb_trace_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk               (clk),
    .rst               (rst),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .trace_valid       (trace_valid),
    .trace_ready       (trace_ready),
    .trace_pc          (trace_pc),
    .trace_wen         (trace_wen),
    .trace_wnum        (trace_wnum),
    .trace_wdata       (trace_wdata),
    .count             (count),
    .overflow          (overflow),
    .drop_cnt          (drop_cnt),
    .clr_ovf           (clr_ovf)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of captured entries plus drop bookkeeping.
  logic [72:0] q[$];
  bit          m_ovf = 1'b0;
  int          m_drops = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      bit cap;
      cap = (debug_wb_rf_wen != 0) && (debug_wb_rf_wnum != 0);
      if (trace_ready && q.size() > 0) void'(q.pop_front());
      if (cap && q.size() < DEPTH) begin
        q.push_back({debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata});
      end else if (cap) begin
        m_ovf   = 1'b1;
        m_drops = clr_ovf ? 1 : ((m_drops < SAT) ? m_drops + 1 : SAT);
      end else if (clr_ovf) begin
        m_ovf   = 1'b0;
        m_drops = 0;
      end
    end
  end

  task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_valid", 73'(trace_valid), 73'(q.size() > 0));
      check("m_count", 73'(count), 73'(q.size()));
      check("m_overflow", 73'(overflow), 73'(m_ovf));
      check("m_drop_cnt", 73'(drop_cnt), 73'(m_drops));
      check("m_entry", {trace_pc, trace_wen, trace_wnum, trace_wdata},
            (q.size() > 0) ? q[0] : 73'd0);
    end
  end

  task automatic set_in(input logic [31:0] pc, input logic [3:0] wen, input logic [4:0] wnum,
                        input logic [31:0] wdata, input logic rdy, input logic clr);
    debug_wb_pc       = pc;
    debug_wb_rf_wen   = wen;
    debug_wb_rf_wnum  = wnum;
    debug_wb_rf_wdata = wdata;
    trace_ready       = rdy;
    clr_ovf           = clr;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    set_in(32'h0, 4'h0, 5'd0, 32'h0, rdy, 1'b0);
  endtask

  initial begin
    #1 rst = 1'b0;
    tick(); tick();
    check("rst_valid", 73'(trace_valid), 73'd0);
    check("rst_count", 73'(count), 73'd0);
    check("rst_ovf", 73'(overflow), 73'd0);
    check("rst_drop", 73'(drop_cnt), 73'd0);
    #2 rst = 1'b1;
    cmp_en = 1'b1;

    // Single capture
    set_in(32'hBFC0_0000, 4'hF, 5'd2, 32'h1234, 1'b0, 1'b0);
    tick();
    check("single_valid", 73'(trace_valid), 73'd1);
    check("single_pc", 73'(trace_pc), 73'h0BFC0_0000);
    check("single_wdata", 73'(trace_wdata), 73'h1234);
    check("single_count", 73'(count), 73'd1);
    idle(1'b1);
    tick();
    check("single_drain", 73'(count), 73'd0);

    // Filter, with trace_ready held while empty
    set_in(32'h100, 4'hF, 5'd0, 32'h1, 1'b1, 1'b0);
    tick();
    set_in(32'h104, 4'h0, 5'd5, 32'h2, 1'b1, 1'b0);
    tick();
    check("filter_count", 73'(count), 73'd0);
    check("filter_valid", 73'(trace_valid), 73'd0);

    // Fill and overflow
    for (int i = 0; i < 10; i++) begin
      set_in(32'h1000 + 32'(4 * i), 4'hF, 5'(i + 1), 32'(i), 1'b0, 1'b0);
      tick();
    end
    check("fill_count", 73'(count), 73'd8);
    check("fill_ovf", 73'(overflow), 73'd1);
    check("fill_drop", 73'(drop_cnt), 73'd2);
    idle(1'b1);
    for (int i = 0; i < 8; i++) begin
      check("fill_order", 73'(trace_pc), 73'(32'h1000 + 32'(4 * i)));
      tick();
    end
    check("fill_empty", 73'(count), 73'd0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 8; i++) begin
      set_in(32'h2000 + 32'(4 * i), 4'h3, 5'd7, 32'(i), 1'b0, 1'b0);
      tick();
    end
    check("pp_full", 73'(count), 73'd8);
    set_in(32'h3000, 4'h1, 5'd9, 32'hABCD, 1'b1, 1'b0);
    tick();
    check("pp_count", 73'(count), 73'd8);
    check("pp_nodrop", 73'(drop_cnt), 73'd2);
    idle(1'b1);
    for (int i = 1; i < 8; i++) begin
      check("pp_order", 73'(trace_pc), 73'(32'h2000 + 32'(4 * i)));
      tick();
    end
    check("pp_last", 73'(trace_pc), 73'h3000);
    tick();

    // Clear collision and saturation
    set_in(32'h0, 4'h0, 5'd0, 32'h0, 1'b0, 1'b1);
    tick();
    check("clr_ovf", 73'(overflow), 73'd0);
    check("clr_drop", 73'(drop_cnt), 73'd0);
    for (int i = 0; i < 13; i++) begin
      set_in(32'h5000 + 32'(4 * i), 4'hF, 5'd31, 32'(i), 1'b0, 1'b0);
      tick();
    end
    check("col_pre_drop", 73'(drop_cnt), 73'd5);
    set_in(32'h6000, 4'hF, 5'd1, 32'h6, 1'b0, 1'b1);
    tick();
    check("col_ovf", 73'(overflow), 73'd1);
    check("col_drop", 73'(drop_cnt), 73'd1);
    set_in(32'h0, 4'h0, 5'd0, 32'h0, 1'b0, 1'b1);
    tick();
    check("col_clr_ovf", 73'(overflow), 73'd0);
    check("col_clr_drop", 73'(drop_cnt), 73'd0);
    for (int i = 0; i < 18; i++) begin
      set_in(32'h7000 + 32'(4 * i), 4'h8, 5'd4, 32'(i), 1'b0, 1'b0);
      tick();
    end
    check("sat_drop", 73'(drop_cnt), 73'd15);

    // Reset mid-operation
    idle(1'b1);
    tick(); tick(); tick();
    check("mid_count", 73'(count), 73'd5);
    idle(1'b0);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid", 73'(trace_valid), 73'd0);
    check("mid_rst_count", 73'(count), 73'd0);
    check("mid_rst_pc", 73'(trace_pc), 73'd0);
    check("mid_rst_ovf", 73'(overflow), 73'd0);
    #1 rst = 1'b1;
    set_in(32'h4444, 4'hF, 5'd6, 32'h55, 1'b0, 1'b0);
    tick();
    check("post_rst_count", 73'(count), 73'd1);
    check("post_rst_pc", 73'(trace_pc), 73'h4444);

    // Captures held off while in reset; first edge after release pushes
    #2 rst = 1'b0;
    set_in(32'h8888, 4'hF, 5'd8, 32'h77, 1'b0, 1'b0);
    tick();
    check("inrst_count", 73'(count), 73'd0);
    #2 rst = 1'b1;
    tick();
    check("release_count", 73'(count), 73'd1);
    check("release_pc", 73'(trace_pc), 73'h8888);
    idle(1'b1);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
